lcd_inst_seq: RTL

HD44780 instruction sequencer for the DE0-Nano LCD path. Steps a 6-bit instruction index through the instruction ROM in the shared package and drives the LCD bus (RS, RW, E, D[7:0]) with spec-compliant setup, strobe and hold timing. After each instruction it hands the index and an enable to `delay_block`, then waits for that block's timeout before issuing the next instruction. It sits directly upstream of `delay_block` and is its only driver.

---
 rtl/lcd_inst_seq_pkg.sv | 34 +++
 rtl/lcd_inst_seq_phase_cnt.sv | 27 ++
 rtl/lcd_inst_seq.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/lcd_inst_seq_pkg.sv
// Shared definitions for the HD44780 instruction path: instruction ROM, sequencer
// state encoding and default bus timing constants.
package lcd_inst_seq_pkg;

  typedef logic [8:0] inst_t;  // {rs, data}

  typedef enum logic [2:0] {
    SEQ_IDLE   = 3'd0,
    SEQ_SETUP  = 3'd1,
    SEQ_STROBE = 3'd2,
    SEQ_HOLD   = 3'd3,
    SEQ_WAIT   = 3'd4,
    SEQ_NEXT   = 3'd5,
    SEQ_DONE   = 3'd6
  } seq_state_t;

  localparam int T_AS_DEF  = 2;
  localparam int T_PW_DEF  = 12;
  localparam int T_AH_DEF  = 2;
  localparam int ROM_DEPTH = 40;
  localparam int PH_W      = 8;

  // 0..7 init commands, 8..23 line 1 "DE0-Nano LCD Seq", 24 line-2 address,
  // 25..39 line 2 "HD44780 demo ok". Index-aligned with the delay table.
  localparam inst_t INST_ROM [0:ROM_DEPTH-1] = '{
    9'h038, 9'h038, 9'h038, 9'h038, 9'h00C, 9'h001, 9'h006, 9'h080,
    9'h144, 9'h145, 9'h130, 9'h12D, 9'h14E, 9'h161, 9'h16E, 9'h16F,
    9'h120, 9'h14C, 9'h143, 9'h144, 9'h120, 9'h153, 9'h165, 9'h171,
    9'h0C0,
    9'h148, 9'h144, 9'h134, 9'h134, 9'h137, 9'h138, 9'h130, 9'h120,
    9'h164, 9'h165, 9'h16D, 9'h16F, 9'h120, 9'h16F, 9'h16B
  };

endpackage

// File: rtl/lcd_inst_seq_phase_cnt.sv
// Loadable down-counter shared by the SETUP, STROBE and HOLD phases; tc is high
// while the count sits at zero, i.e. in the last cycle of the current phase.
import lcd_inst_seq_pkg::*;

module lcd_phase_cnt (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_load,
  input  logic [PH_W-1:0] i_load_val,
  output logic            o_tc
);

  logic [PH_W-1:0] cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt <= '0;
    end else if (i_load) begin
      cnt <= i_load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign o_tc = (cnt == '0);

endmodule

// File: rtl/lcd_inst_seq.sv
// HD44780 instruction sequencer: walks INST_ROM, drives RS/RW/E/D with setup,
// strobe and hold timing, then hands off to delay_block. Option: LCD_SEQ_REPEAT_EN.
import lcd_inst_seq_pkg::*;

module lcd_inst_seq #(
  parameter int INST_NUM   = 24,
  parameter int T_AS       = T_AS_DEF,
  parameter int T_PW       = T_PW_DEF,
  parameter int T_AH       = T_AH_DEF,
  parameter int REPEAT_IDX = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_delay_TO,
  output logic [5:0] o_inst_cnt,
  output logic       o_delay_enb,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic       o_lcd_e,
  output logic [7:0] o_lcd_data,
  output logic       o_busy,
  output logic       o_done,
  output logic [2:0] o_dbg_state
);

  localparam logic [2:0] ST_IDLE   = 3'(SEQ_IDLE);
  localparam logic [2:0] ST_SETUP  = 3'(SEQ_SETUP);
  localparam logic [2:0] ST_STROBE = 3'(SEQ_STROBE);
  localparam logic [2:0] ST_HOLD   = 3'(SEQ_HOLD);
  localparam logic [2:0] ST_WAIT   = 3'(SEQ_WAIT);
  localparam logic [2:0] ST_NEXT   = 3'(SEQ_NEXT);
  localparam logic [2:0] ST_DONE   = 3'(SEQ_DONE);

  localparam logic [5:0]      IDX_LAST = 6'(INST_NUM - 1);
  localparam logic [PH_W-1:0] AS_LD    = PH_W'(T_AS - 1);
  localparam logic [PH_W-1:0] PW_LD    = PH_W'(T_PW - 1);
  localparam logic [PH_W-1:0] AH_LD    = PH_W'(T_AH - 1);

  if (INST_NUM < 1 || INST_NUM > ROM_DEPTH || REPEAT_IDX < 0 || REPEAT_IDX >= INST_NUM ||
      T_AS < 1 || T_PW < 1 || T_AH < 1 ||
      T_AS > (1 << PH_W) || T_PW > (1 << PH_W) || T_AH > (1 << PH_W)) begin : g_bad_params
    $error("lcd_inst_seq: parameter out of range");
  end

  logic [2:0]      state;
  logic            ph_load;
  logic [PH_W-1:0] ph_val;
  logic            ph_tc;
  logic            last_inst;
  logic            go_done;
  logic [5:0]      nxt_idx;

  assign last_inst = (o_inst_cnt == IDX_LAST);

`ifdef LCD_SEQ_REPEAT_EN
  // The init block runs once; the data-write block loops forever.
  assign go_done = 1'b0;
  assign nxt_idx = last_inst ? 6'(REPEAT_IDX) : o_inst_cnt + 6'd1;
`else
  assign go_done = last_inst;
  assign nxt_idx = o_inst_cnt + 6'd1;
`endif

  // The phase counter is reloaded on every entry into SETUP, STROBE or HOLD.
  always_comb begin
    ph_load = 1'b0;
    ph_val  = AS_LD;
    case (state)
      ST_IDLE, ST_DONE: ph_load = i_start;
      ST_SETUP: begin
        ph_load = ph_tc;
        ph_val  = PW_LD;
      end
      ST_STROBE: begin
        ph_load = ph_tc;
        ph_val  = AH_LD;
      end
      ST_NEXT: ph_load = !go_done;
      default: ph_load = 1'b0;
    endcase
  end

  lcd_phase_cnt u_phase_cnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (ph_load),
    .i_load_val (ph_val),
    .o_tc       (ph_tc)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      o_inst_cnt  <= 6'd0;
      o_delay_enb <= 1'b0;
      o_lcd_rs    <= 1'b0;
      o_lcd_e     <= 1'b0;
      o_lcd_data  <= 8'h00;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            state                  <= ST_SETUP;
            o_inst_cnt             <= 6'd0;
            {o_lcd_rs, o_lcd_data} <= INST_ROM[0];
            o_busy                 <= 1'b1;
            o_done                 <= 1'b0;
          end
        end
        ST_SETUP: begin
          if (ph_tc) begin
            state   <= ST_STROBE;
            o_lcd_e <= 1'b1;
          end
        end
        ST_STROBE: begin
          if (ph_tc) begin
            state   <= ST_HOLD;
            o_lcd_e <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (ph_tc) begin
            state       <= ST_WAIT;
            o_delay_enb <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (i_delay_TO) begin
            state       <= ST_NEXT;
            o_delay_enb <= 1'b0;
          end
        end
        ST_NEXT: begin
          if (go_done) begin
            state  <= ST_DONE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
          end else begin
            state                  <= ST_SETUP;
            o_inst_cnt             <= nxt_idx;
            {o_lcd_rs, o_lcd_data} <= INST_ROM[nxt_idx];
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Write-only interface: the busy flag is never read back from the panel.
  assign o_lcd_rw    = 1'b0;
  assign o_dbg_state = state;

endmodule
